tx_block: RTL and testbench

UART transmitter that pairs with the existing receive path: accepts a parallel byte from the host side, buffers it, and serializes it onto a single line. Frames are 1 start bit (0), 8 data bits sent LSB first, and 1 stop bit (1). Each bit is held for BIT_PERIOD clocks, so the frame matches what the receive block samples. A one-deep holding buffer lets the host queue the next byte while the current frame shifts out, which allows back-to-back frames.

---
 rtl/tx_block.sv | 147 ++++++++++++++
 tb/tb_tx_block.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_block.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit, one-deep holding buffer.
// Define TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module tx_block #(
  parameter int BIT_PERIOD = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       load_data,
  output logic       serial_out,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       overrun_error
);

  localparam logic [7:0] LAST = 8'(BIT_PERIOD - 1);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t     state_q;
  logic [7:0] clk_cnt_q;
  logic [7:0] clk_cnt_d;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] hold_q;
  logic       parity_q;
  logic       serial_q;
  logic       ready_q;
  logic       busy_q;
  logic       overrun_q;
  logic       bit_end;
  logic       take_buf;

  assign serial_out    = serial_q;
  assign tx_ready      = ready_q;
  assign tx_busy       = busy_q;
  assign overrun_error = overrun_q;

  // A full buffer is drained either from IDLE or at the end of a stop bit.
  always_comb begin
    bit_end   = (clk_cnt_q == LAST);
    clk_cnt_d = bit_end ? 8'd0 : clk_cnt_q + 8'd1;
    take_buf  = !ready_q &&
                ((state_q == IDLE) || ((state_q == STOP) && bit_end));
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= 8'd0;
      bit_cnt_q <= 3'd0;
      serial_q  <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // Acceptance is judged on the pre-edge ready flag, so a load can never race a drain.
      if (take_buf)
        ready_q <= 1'b1;
      if (load_data) begin
        if (ready_q) begin
          hold_q    <= tx_data;
          ready_q   <= 1'b0;
          overrun_q <= 1'b0;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          serial_q  <= 1'b1;
          clk_cnt_q <= 8'd0;
          if (!ready_q) begin
            shift_q   <= hold_q;
            parity_q  <= ^hold_q;
            bit_cnt_q <= 3'd0;
            serial_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          clk_cnt_q <= clk_cnt_d;
          if (bit_end) begin
            serial_q <= shift_q[0];
            state_q  <= DATA;
          end
        end
        DATA: begin
          clk_cnt_q <= clk_cnt_d;
          if (bit_end) begin
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef TX_PARITY_EN
              serial_q <= parity_q;
              state_q  <= PARITY;
`else
              serial_q <= 1'b1;
              state_q  <= STOP;
`endif
            end else begin
              serial_q <= shift_q[1];
            end
          end
        end
`ifdef TX_PARITY_EN
        PARITY: begin
          clk_cnt_q <= clk_cnt_d;
          if (bit_end) begin
            serial_q <= 1'b1;
            state_q  <= STOP;
          end
        end
`endif
        STOP: begin
          clk_cnt_q <= clk_cnt_d;
          if (bit_end) begin
            if (!ready_q) begin
              shift_q   <= hold_q;
              parity_q  <= ^hold_q;
              bit_cnt_q <= 3'd0;
              serial_q  <= 1'b0;
              state_q   <= START;
            end else begin
              serial_q <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        default: begin
          serial_q  <= 1'b1;
          busy_q    <= 1'b0;
          clk_cnt_q <= 8'd0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_block.sv
// Directed bench for tx_block: reset, single frame, back-to-back, overrun, mid-frame reset, parity.
module tb_tx_block;

  localparam int BP = 10;
`ifdef TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       load_data;
  logic       serial_out;
  logic       tx_ready;
  logic       tx_busy;
  logic       overrun_error;

  int checks = 0;
  int errors = 0;

  tx_block #(.BIT_PERIOD(BP)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_data      (tx_data),
    .load_data    (load_data),
    .serial_out   (serial_out),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .overrun_error(overrun_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] b);
    tx_data   = b;
    load_data = 1'b1;
    tick();
    load_data = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Entered just after the edge that starts the frame; leaves just after the frame's last cycle.
  task automatic check_frame(input logic [7:0] b, input int i1, input logic [7:0] b1,
                             input int i2, input logic [7:0] b2);
    logic exp;
    for (int c = 0; c < NBITS*BP; c++) begin
      exp = frame_bit(b, c / BP);
      checks++;
      if (serial_out !== exp || tx_busy !== 1'b1) begin
        errors++;
        $display("FAIL frame_%h cyc %0d: serial_out=%b tx_busy=%b, expected serial_out=%b tx_busy=1",
                 b, c, serial_out, tx_busy, exp);
      end
      if (c == i1) begin
        tx_data = b1; load_data = 1'b1;
      end else if (c == i2) begin
        tx_data = b2; load_data = 1'b1;
      end else begin
        load_data = 1'b0;
      end
      tick();
    end
    load_data = 1'b0;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (tx_busy !== 1'b0 || serial_out !== 1'b1) begin
      errors++;
      $display("FAIL %s: tx_busy=%b serial_out=%b, expected tx_busy=0 serial_out=1",
               name, tx_busy, serial_out);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; load_data = 1'b0; tx_data = 8'h00;
    tick(); tick();
    checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL reset_serial: got %b expected 1", serial_out); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun_error); end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    load(8'hA5);
    checks++;
    if (tx_ready !== 1'b0 || tx_busy !== 1'b0 || serial_out !== 1'b1) begin
      errors++;
      $display("FAIL single_loaded: ready=%b busy=%b serial=%b, expected 0 0 1", tx_ready, tx_busy, serial_out);
    end
    tick();
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL single_ready_after_xfer: got %b expected 1", tx_ready); end
    check_frame(8'hA5, -1, 8'h00, -1, 8'h00);
    check_idle("single_end");
    tick();
  endtask

  task automatic test_back_to_back();
    load(8'h3C);
    tick();
    check_frame(8'h3C, 25, 8'hF0, -1, 8'h00);
    checks++;
    if (overrun_error !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun_error); end
    check_frame(8'hF0, -1, 8'h00, -1, 8'h00);
    check_idle("b2b_end");
    tick();
  endtask

  task automatic test_overrun();
    load(8'h11);
    tick();
    check_frame(8'h11, 2, 8'h22, 5, 8'h33);
    checks++;
    if (overrun_error !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun_error); end
    check_frame(8'h22, -1, 8'h00, -1, 8'h00);
    check_idle("overrun_after_22");
    for (int c = 0; c < 3*BP; c++) begin
      checks++;
      if (serial_out !== 1'b1 || tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL overrun_no_33 cyc %0d: serial=%b ready=%b expected 1 1", c, serial_out, tx_ready);
      end
      tick();
    end
    checks++;
    if (overrun_error !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", overrun_error); end
    load(8'h55);
    checks++;
    if (overrun_error !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b expected 0", overrun_error); end
    tick();
    check_frame(8'h55, -1, 8'h00, -1, 8'h00);
    check_idle("overrun_end");
    tick();
  endtask

  task automatic test_reset_mid();
    load(8'h52);
    tick();
    for (int c = 0; c < 45; c++) begin
      load_data = (c == 20);
      tx_data   = 8'h99;
      tick();
    end
    load_data = 1'b0;
    checks++;
    if (serial_out !== 1'b0 || tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_pre: serial=%b ready=%b expected 0 0", serial_out, tx_ready);
    end
    n_rst = 1'b0;
    tick();
    checks++;
    if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_edge: serial=%b busy=%b ready=%b expected 1 0 1", serial_out, tx_busy, tx_ready);
    end
    n_rst = 1'b1;
    for (int c = 0; c < 12*BP; c++) begin
      tick();
      checks++;
      if (serial_out !== 1'b1 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL midrst_quiet cyc %0d: serial=%b busy=%b ready=%b expected 1 0 1",
                 c, serial_out, tx_busy, tx_ready);
      end
    end
  endtask

`ifdef TX_PARITY_EN
  task automatic test_parity();
    load(8'h07);
    tick();
    checks++;
    if (frame_bit(8'h07, 9) !== 1'b1) begin errors++; $display("FAIL parity_model: got 0 expected 1"); end
    check_frame(8'h07, -1, 8'h00, -1, 8'h00);
    check_idle("parity_end");
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
`ifdef TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
